// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start, data (LSB/MSB first), optional parity, stop.
// Optional even parity bit enabled by defining SERIAL_FRAME_PARITY_EN.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lsb_first,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sh;
  logic             dir;
  logic             wrap;
`ifdef SERIAL_FRAME_PARITY_EN
  logic             par;
`endif

  assign wrap    = (cnt == LAST);
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rest) begin
      state    <= IDLE;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      dir      <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sh       <= data_in;
            dir      <= lsb_first;
`ifdef SERIAL_FRAME_PARITY_EN
            par      <= ^data_in;
`endif
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            cnt      <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          cnt <= cnt_nxt;
          if (wrap) begin
            state <= DATA;
            tx    <= dir ? sh[0] : sh[WIDTH-1];
          end
        end
        DATA: begin
          cnt <= cnt_nxt;
          if (wrap) begin
            if (bit_cnt == BLAST) begin
`ifdef SERIAL_FRAME_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
              done  <= (CLKS_PER_BIT == 1);
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sh      <= dir ? (sh >> 1) : (sh << 1);
              tx      <= dir ? sh[1] : sh[WIDTH-2];
            end
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        PARITY: begin
          cnt <= cnt_nxt;
          if (wrap) begin
            state <= STOP;
            tx    <= 1'b1;
            done  <= (CLKS_PER_BIT == 1);
          end
        end
`endif
        STOP: begin
          cnt <= cnt_nxt;
          if (wrap) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            done     <= 1'b0;
          end else begin
            // done must land on the final stop cycle
            done <= (cnt == PRE);
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          done     <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table vectors, corner sequences, random frames.
// Expected tx stream comes from hand tables or a per-bit list model.
module tb_serial_frame_tx;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rest;
  logic [W-1:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic         lsb_first;
  logic         tx;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];

  typedef struct {
    logic [7:0] word;
    logic       lsb;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t tbl[6];

  serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rest(rest),
    .data_in(data_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lsb_first(lsb_first),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, string sig, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %b want %b t=%0t",
                  tag, sig, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(string tag);
    chk(tag, "tx", tx, 1'b1);
    chk(tag, "busy", busy, 1'b0);
    chk(tag, "in_ready", in_ready, 1'b1);
    chk(tag, "done", done, 1'b0);
  endtask

  task automatic push_bit(bit b);
    repeat (C) exp_q.push_back(b);
  endtask

  // seq holds data bits in wire order, first bit at [7]
  task automatic build_tbl(vec_t v);
    exp_q.delete();
    push_bit(1'b0);
    for (int j = 7; j >= 0; j--) push_bit(v.seq[j]);
`ifdef SERIAL_FRAME_PARITY_EN
    push_bit(v.par);
`endif
    push_bit(1'b1);
  endtask

  task automatic build_model(logic [W-1:0] w, logic lsb);
    exp_q.delete();
    push_bit(1'b0);
    for (int j = 0; j < W; j++) push_bit(w[lsb ? j : W-1-j]);
`ifdef SERIAL_FRAME_PARITY_EN
    push_bit(^w);
`endif
    push_bit(1'b1);
  endtask

  // Caller leaves DUT idle with inputs set; next edge accepts.
  task automatic run_frame(string tag, bit hold, logic [W-1:0] alt);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0 && !hold) in_valid = 1'b0;
      if (i == n/2 && hold) begin
        data_in   = alt;
        lsb_first = ~lsb_first;
      end
      chk(tag, "tx", tx, exp_q[i]);
      chk(tag, "busy", busy, 1'b1);
      chk(tag, "in_ready", in_ready, 1'b0);
      chk(tag, "done", done, i == n-1);
    end
    tick();
    idle_chk(tag);
  endtask

  task automatic start(logic [W-1:0] w, logic lsb);
    data_in   = w;
    lsb_first = lsb;
    in_valid  = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    logic         l;
    int           gap;

    tbl[0] = '{8'hF0, 1'b1, 8'b00001111, 1'b0};
    tbl[1] = '{8'hF0, 1'b0, 8'b11110000, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 8'b11100000, 1'b1};
    tbl[3] = '{8'h07, 1'b0, 8'b00000111, 1'b1};
    tbl[4] = '{8'hA5, 1'b1, 8'b10100101, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 8'b00111100, 1'b0};

    rest      = 1'b1;
    in_valid  = 1'b1;
    data_in   = 8'hF0;
    lsb_first = 1'b1;
    tick();
    idle_chk("rst1");
    tick();
    idle_chk("rst2");
    rest     = 1'b0;
    in_valid = 1'b0;
    tick();
    idle_chk("post_rst");

    for (int t = 0; t < 5; t++) begin
      build_tbl(tbl[t]);
      start(tbl[t].word, tbl[t].lsb);
      run_frame($sformatf("tbl%0d", t), 1'b0, '0);
    end

    // held valid, word changed mid-frame, then back-to-back accept
    build_tbl(tbl[0]);
    start(8'hF0, 1'b1);
    run_frame("hold1", 1'b1, 8'h3C);
    build_tbl(tbl[5]);
    run_frame("hold2", 1'b0, '0);

    // reset during data bit 3
    build_model(8'h5A, 1'b1);
    start(8'h5A, 1'b1);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 0) in_valid = 1'b0;
      chk("pre_abort", "tx", tx, exp_q[i]);
    end
    rest = 1'b1;
    tick();
    idle_chk("abort");
    rest = 1'b0;
    tick();
    idle_chk("abort_idle");
    build_model(8'hC3, 1'b0);
    start(8'hC3, 1'b0);
    run_frame("fresh", 1'b0, '0);

    for (int r = 0; r < 20; r++) begin
      w   = W'($urandom);
      l   = 1'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        tick();
        idle_chk("gap");
      end
      build_model(w, l);
      start(w, l);
      run_frame($sformatf("rnd%0d", r), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
